prog_mod_counter: RTL and testbench

//   Parametrised programmable-modulus up/down counter. Successor to the plain
//   n-bit free-running up-counter in the ClockDivider library.

---
 rtl/prog_mod_counter.sv | 93 +++++++++
 tb/tb_prog_mod_counter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - programmable-modulus up/down counter with wrap strobe, divided clock and PWM
//
// Purpose: counts 0..Modulus up or down with run-time modulus, enable, synchronous
// clear/load, a one-cycle terminal-count strobe, a toggle-on-wrap clock output and
// a PWM compare output. Core of programmable clock dividers and tick generators.
//
// Ports:
//   nReset    in  1  asynchronous active-low reset
//   Clk       in  1  clock, rising edge
//   Enable    in  1  count enable (hold when low)
//   Up        in  1  1 = count up, 0 = count down
//   Clear     in  1  synchronous clear (highest priority)
//   Load      in  1  synchronous load of LoadValue
//   LoadValue in  N  value taken on Load
//   Modulus   in  N  terminal value, count range 0..Modulus
//   Duty      in  N  PWM compare threshold
//   Count     out N  registered counter value
//   TC        out 1  registered one-cycle wrap strobe
//   ClkOut    out 1  registered, toggles on every wrap
//   PwmOut    out 1  registered, next Count < Duty
module prog_mod_counter #(
    parameter int N        = 8,
    parameter int TC_RESET = 0
) (
    input  logic         nReset,
    input  logic         Clk,
    input  logic         Enable,
    input  logic         Up,
    input  logic         Clear,
    input  logic         Load,
    input  logic [N-1:0] LoadValue,
    input  logic [N-1:0] Modulus,
    input  logic [N-1:0] Duty,
    output logic [N-1:0] Count,
    output logic         TC,
    output logic         ClkOut,
    output logic         PwmOut
);

    localparam logic CLK_INIT = (TC_RESET != 0);

    logic [N-1:0] next_count;
    logic         wrap;

    // Next-state selection. The >= / > compares against Modulus keep +1/-1 from
    // ever wrapping through 2^N, including after a Load above Modulus.
    always_comb begin
        next_count = Count;
        wrap       = 1'b0;
        if (Clear) begin
            next_count = '0;
        end else if (Load) begin
            next_count = LoadValue;
        end else if (Enable) begin
            if (Up) begin
                if (Count >= Modulus) begin
                    next_count = '0;
                    wrap       = 1'b1;
                end else begin
                    next_count = Count + N'(1);
                end
            end else begin
                if (Count == '0) begin
                    next_count = Modulus;
                    wrap       = 1'b1;
                end else if (Count > Modulus) begin
                    // Out-of-range value after a Load: resync, not a wrap.
                    next_count = Modulus;
                end else begin
                    next_count = Count - N'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Count  <= '0;
            TC     <= 1'b0;
            ClkOut <= CLK_INIT;
            PwmOut <= 1'b0;
        end else begin
            Count  <= next_count;
            TC     <= wrap;
            if (wrap) begin
                ClkOut <= ~ClkOut;
            end
            // Compare against the value being written so PwmOut lines up with Count.
            PwmOut <= (next_count < Duty);
        end
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - self-checking bench for prog_mod_counter
module tb_prog_mod_counter;

    localparam int N        = 8;
    localparam int TC_RESET = 1;

    logic         nReset;
    logic         Clk;
    logic         Enable;
    logic         Up;
    logic         Clear;
    logic         Load;
    logic [N-1:0] LoadValue;
    logic [N-1:0] Modulus;
    logic [N-1:0] Duty;
    logic [N-1:0] Count;
    logic         TC;
    logic         ClkOut;
    logic         PwmOut;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_count;
    int m_tc;
    int m_clk;
    int m_pwm;

    prog_mod_counter #(.N(N), .TC_RESET(TC_RESET)) dut (
        .nReset    (nReset),
        .Clk       (Clk),
        .Enable    (Enable),
        .Up        (Up),
        .Clear     (Clear),
        .Load      (Load),
        .LoadValue (LoadValue),
        .Modulus   (Modulus),
        .Duty      (Duty),
        .Count     (Count),
        .TC        (TC),
        .ClkOut    (ClkOut),
        .PwmOut    (PwmOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_count = 0;
        m_tc    = 0;
        m_clk   = TC_RESET;
        m_pwm   = 0;
    endtask

    // One clock edge of the counter described as plain integer arithmetic.
    task automatic model_step();
        int md;
        int c;
        md   = int'(Modulus);
        c    = m_count;
        m_tc = 0;
        if (Clear) begin
            c = 0;
        end else if (Load) begin
            c = int'(LoadValue);
        end else if (Enable) begin
            if (Up) begin
                if (c >= md) begin
                    c = 0; m_tc = 1; m_clk = 1 - m_clk;
                end else begin
                    c = c + 1;
                end
            end else begin
                if (c == 0) begin
                    c = md; m_tc = 1; m_clk = 1 - m_clk;
                end else if (c > md) begin
                    c = md;
                end else begin
                    c = c - 1;
                end
            end
        end
        m_count = c;
        m_pwm   = (c < int'(Duty)) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        model_step();
    endtask

    task automatic set_inputs(input logic en, input logic up, input logic clr, input logic ld);
        Enable = en; Up = up; Clear = clr; Load = ld;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        set_inputs(0, 1, 0, 0);
        LoadValue = '0; Modulus = 8'd9; Duty = '0;
        model_reset();
        #12;
        checks++;
        if ({Count, TC, ClkOut, PwmOut} !== {8'd0, 1'b0, 1'(TC_RESET), 1'b0}) begin
            errors++;
            $display("FAIL reset_init: got Count=%0d TC=%0b ClkOut=%0b Pwm=%0b, want 0 0 %0d 0",
                     Count, TC, ClkOut, PwmOut, TC_RESET);
        end
        @(negedge Clk);
        nReset = 1'b1;
        Duty = 8'd4;
        set_inputs(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (Count !== 8'd5 || m_count != 5) begin
            errors++;
            $display("FAIL reset_precount: got Count=%0d, want 5", Count);
        end
        // Assert reset between edges: outputs must clear with no clock.
        #2;
        nReset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({Count, TC, ClkOut, PwmOut} !== {8'd0, 1'b0, 1'(TC_RESET), 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got Count=%0d TC=%0b ClkOut=%0b Pwm=%0b, want 0 0 %0d 0",
                     Count, TC, ClkOut, PwmOut, TC_RESET);
        end
        #2;
        nReset = 1'b1;
    endtask

    task automatic test_up();
        int last_toggle;
        int prev_clk;
        set_inputs(0, 1, 1, 0);
        Modulus = 8'd4;
        tick();
        set_inputs(1, 1, 0, 0);
        last_toggle = -1;
        prev_clk = ClkOut;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (Count !== 8'((i + 1) % 5) || TC !== (Count == 8'd0)) begin
                errors++;
                $display("FAIL up_seq[%0d]: got Count=%0d TC=%0b, want Count=%0d TC=%0b",
                         i, Count, TC, (i + 1) % 5, ((i + 1) % 5) == 0);
            end
            if (ClkOut !== 1'(prev_clk)) begin
                if (last_toggle >= 0) begin
                    checks++;
                    if (i - last_toggle != 5) begin
                        errors++;
                        $display("FAIL up_clkout_half_period: got %0d edges, want 5", i - last_toggle);
                    end
                end
                last_toggle = i;
                prev_clk = ClkOut;
            end
        end
        checks++;
        if (ClkOut !== 1'(m_clk)) begin
            errors++;
            $display("FAIL up_clkout: got %0b, want %0d", ClkOut, m_clk);
        end
    endtask

    task automatic test_down();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        set_inputs(0, 0, 1, 0);
        Modulus = 8'd3;
        tick();
        set_inputs(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (Count !== exp_seq[i] || TC !== (i == 0 || i == 4)) begin
                errors++;
                $display("FAIL down_seq[%0d]: got Count=%0d TC=%0b, want Count=%0d TC=%0b",
                         i, Count, TC, exp_seq[i], (i == 0 || i == 4));
            end
        end
        LoadValue = 8'd9;
        set_inputs(1, 0, 0, 1);
        tick();
        checks++;
        if (Count !== 8'd9 || TC !== 1'b0) begin
            errors++;
            $display("FAIL down_load: got Count=%0d TC=%0b, want 9 0", Count, TC);
        end
        set_inputs(1, 0, 0, 0);
        tick();
        checks++;
        if (Count !== 8'd3 || TC !== 1'b0) begin
            errors++;
            $display("FAIL down_resync: got Count=%0d TC=%0b, want 3 0", Count, TC);
        end
    endtask

    task automatic test_priority();
        Modulus = 8'd9;
        LoadValue = 8'd7;
        set_inputs(1, 1, 1, 1);
        tick();
        checks++;
        if (Count !== 8'd0 || TC !== 1'b0) begin
            errors++;
            $display("FAIL prio_clear: got Count=%0d TC=%0b, want 0 0", Count, TC);
        end
        set_inputs(1, 1, 0, 1);
        tick();
        checks++;
        if (Count !== 8'd7 || TC !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: got Count=%0d TC=%0b, want 7 0", Count, TC);
        end
        set_inputs(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Count !== 8'd7 || TC !== 1'b0) begin
                errors++;
                $display("FAIL prio_hold[%0d]: got Count=%0d TC=%0b, want 7 0", i, Count, TC);
            end
        end
    endtask

    task automatic test_mod0();
        logic prev;
        set_inputs(0, 1, 1, 0);
        Modulus = 8'd0;
        tick();
        set_inputs(1, 1, 0, 0);
        prev = ClkOut;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (Count !== 8'd0 || TC !== 1'b1 || ClkOut !== ~prev) begin
                errors++;
                $display("FAIL mod0[%0d]: got Count=%0d TC=%0b ClkOut=%0b, want 0 1 %0b",
                         i, Count, TC, ClkOut, ~prev);
            end
            prev = ClkOut;
        end
    endtask

    task automatic test_pwm();
        set_inputs(0, 1, 1, 0);
        Modulus = 8'd9;
        Duty = 8'd3;
        tick();
        set_inputs(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (PwmOut !== (Count < 8'd3)) begin
                errors++;
                $display("FAIL pwm_duty3[%0d]: got Pwm=%0b at Count=%0d, want %0b",
                         i, PwmOut, Count, (Count < 8'd3));
            end
        end
        Duty = 8'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (PwmOut !== 1'b0) begin
                errors++;
                $display("FAIL pwm_duty0[%0d]: got Pwm=%0b, want 0", i, PwmOut);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Enable    = ($urandom_range(0, 9) != 0);
            Up        = $urandom_range(0, 1) == 1;
            Clear     = ($urandom_range(0, 39) == 0);
            Load      = ($urandom_range(0, 29) == 0);
            LoadValue = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 49) == 0) Modulus = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) Duty = 8'($urandom_range(0, 14));
            tick();
            checks++;
            if ({Count, TC, ClkOut, PwmOut} !==
                {8'(m_count), 1'(m_tc), 1'(m_clk), 1'(m_pwm)}) begin
                errors++;
                $display("FAIL random[%0d]: got Count=%0d TC=%0b ClkOut=%0b Pwm=%0b, want %0d %0d %0d %0d",
                         i, Count, TC, ClkOut, PwmOut, m_count, m_tc, m_clk, m_pwm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_priority();
        test_mod0();
        test_pwm();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
